data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//   Round-robin arbiter/sequencer sharing the single-port, byte-addressed data_mem between NUM_REQ
//   requesters (core LSU, vector lanes, DMA). Accepts one word request at a time, drives data_mem's
//   WDME/A/WD and samples RD. Returns a per-requester response pulse. Rejects misaligned and
//   out-of-range accesses without touching memory.
// PARAMETERS
//   NUM_REQ         4   number of requesters (>=2); ID_W = $clog2(NUM_REQ)
//   DATA_WIDTH      32  word width; fixed at 32 to match data_mem word access
//   ADDR_WIDTH      32  address width on request and memory side
//   ADDR_REAL_WIDTH 20  implemented byte locations = 2**ADDR_REAL_WIDTH
// PORTS
//   clk        in   1                    clock; all state updates on posedge
//   rst_n      in   1                    asynchronous, active-low reset
//   req_valid  in   NUM_REQ              request pending, one bit per requester
//   req_we     in   NUM_REQ              1 = store word, 0 = load word
//   req_addr   in   NUM_REQ*ADDR_WIDTH   packed byte addresses; requester i at [i*AW +: AW]
//   req_wdata  in   NUM_REQ*DATA_WIDTH   packed store data; requester i at [i*DW +: DW]
//   req_ready  out  NUM_REQ              one-hot accept strobe; combinational in IDLE
//   rsp_valid  out  NUM_REQ              one-hot 1-cycle response pulse
//   rsp_rdata  out  DATA_WIDTH           load data, valid with rsp_valid; 0 for stores and errors
//   rsp_err    out  1                    misaligned/out-of-range flag, valid with rsp_valid
//   busy       out  1                    state != IDLE
//   mem_we     out  1                    to data_mem WDME
//   mem_addr   out  ADDR_WIDTH           to data_mem A
//   mem_wdata  out  DATA_WIDTH           to data_mem WD
//   mem_rdata  in   DATA_WIDTH           from data_mem RD (combinational read)
// BEHAVIOUR
//   - FSM: IDLE -> ACCESS -> RESP -> IDLE. Fixed 3-cycle cost; no pipelining or back-to-back overlap.
//   - IDLE: if any req_valid, select winner = first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//     Assert req_ready[winner] this cycle. On the edge: latch id/we/addr/wdata, compute
//     err = (addr[1:0]!=0) | (addr > 2**ADDR_REAL_WIDTH-4), rr_ptr <= (winner+1) mod NUM_REQ,
//     go to ACCESS. No req_valid: stay in IDLE, rr_ptr unchanged.
//   - ACCESS: mem_addr = latched addr, mem_wdata = latched wdata, mem_we = we & ~err (write lands
//     at this cycle's edge). On the edge: rdata_q <= (we|err) ? 0 : mem_rdata; go to RESP.
//   - RESP: rsp_valid[id]=1, rsp_rdata=rdata_q, rsp_err=err_q; go to IDLE; no accept this cycle.
//   - Outside ACCESS: mem_we=0, mem_addr=0, mem_wdata=0. Outside RESP: rsp_valid=0, rsp_rdata=0,
//     rsp_err=0.
//   - Handshake: a requester holds valid/we/addr/wdata stable until it sees req_ready, then
//     deasserts or issues its next request. Ready is only asserted when valid is high.
//   - Fairness: a continuously requesting master waits at most (NUM_REQ-1) grants.
//   - Address wrap: addr+3 must not exceed the array; the top 3 bytes fall under the range error.
//   - Reset (async, any state): state=IDLE, rr_ptr=0, all latches 0, every output 0 immediately.
//     A store in ACCESS is aborted if rst_n falls before its edge. An interrupted request gets
//     no response; the requester reissues it.
// TESTING
//   1 Req0 load 0x100 (mem word 0xDEADBEEF): ready0 @c0, mem_addr=0x100 @c1,
//     rsp_valid0 + rdata=0xDEADBEEF @c2, err=0.
//   2 Req2 store 0x12345678 @0x200, then req2 load 0x200: rdata=0x12345678;
//     bytes 0x200..0x203 = 78,56,34,12.
//   3 All 4 valid continuously from reset: grant order 0,1,2,3,0; one grant every 3 cycles;
//     each rsp_valid on the granted id only.
//   4 Req1 store @0x102 and load @0xFFFFE: rsp_err=1, rdata=0, mem_we never asserted,
//     memory unchanged.
//   5 rst_n low during ACCESS of a store to 0x300: mem_we drops immediately; 0x300 keeps its
//     old value; outputs 0; next request granted to req0 first.
//   6 rr_ptr=2 with only req0 and req3 valid: req3 granted first, then req0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port, byte-addressed data memory between NUM_REQ requesters.
// Each accepted word request walks IDLE -> ACCESS -> RESP; misaligned or out-of-range accesses never reach memory.
module data_mem_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int ADDR_REAL_WIDTH = 20
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_err,
    output logic                           busy,
    output logic                           mem_we,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic [DATA_WIDTH-1:0]          mem_rdata
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Highest legal word address: the full word addr..addr+3 must fit in the array.
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT =
        ADDR_WIDTH'((64'd1 << ADDR_REAL_WIDTH) - 64'd4);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e                 state_q,  state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]        id_q,     id_d;
    logic                   we_q,     we_d;
    logic                   err_q,    err_d;
    logic [ADDR_WIDTH-1:0]  addr_q,   addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q,  wdata_d;
    logic [DATA_WIDTH-1:0]  rdata_q,  rdata_d;

    logic                   grant_found;
    logic [ID_W-1:0]        winner;
    logic                   sel_we;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;

    // Round-robin scan starting at rr_ptr, then mux out the winner's request fields.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        grant_found = 1'b0;
        winner      = '0;
        sel_we      = 1'b0;
        sel_addr    = '0;
        sel_wdata   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int              pos;
            logic [ID_W-1:0] idx;
            pos = int'(rr_ptr_q) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            idx = ID_W'(pos);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                winner      = idx;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == winner) begin
                sel_we    = req_we[k];
                sel_addr  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        we_d     = we_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    id_d     = winner;
                    we_d     = sel_we;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    err_d    = (sel_addr[1:0] != 2'b00) || (sel_addr > ADDR_LIMIT);
                    rr_ptr_d = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                rdata_d = (we_q || err_q) ? '0 : mem_rdata;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = (state_q != ST_IDLE);
        // Gate the combinational accept with rst_n so every output is 0 while reset is held.
        if (state_q == ST_IDLE && grant_found && rst_n) begin
            req_ready[winner] = 1'b1;
        end
        if (state_q == ST_ACCESS) begin
            mem_we    = we_q & ~err_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
        if (state_q == ST_RESP) begin
            rsp_valid[id_q] = 1'b1;
            rsp_rdata       = rdata_q;
            rsp_err         = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            we_q     <= we_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: byte-addressed memory model, per-requester driver queues,
// and a scoreboard monitor comparing each response pulse against hand-computed expectations.
module tb_data_mem_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int ARW = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    data_mem_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_REAL_WIDTH(ARW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] cyc;
    } gl_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mem_we_cnt = 0;
    req_t rq [NR][8];
    int   rq_cnt [NR];
    int   rq_head [NR];
    exp_t exp_q [$];
    gl_t  grant_log [$];

    logic [7:0] mem [0:(1<<ARW)-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_word(input logic [ARW-1:0] a);
        return {mem[a + 2'd3], mem[a + 2'd2], mem[a + 2'd1], mem[a]};
    endfunction

    // Byte-addressed single-port memory: combinational read, write on posedge when mem_we.
    logic [ARW-1:0] ma0, ma1, ma2, ma3;
    assign ma0 = mem_addr[ARW-1:0];
    assign ma1 = ma0 + 1'b1;
    assign ma2 = ma0 + 2'd2;
    assign ma3 = ma0 + 2'd3;
    assign mem_rdata = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};

    task automatic preload(input logic [ARW-1:0] a, input logic [DW-1:0] w);
        mem[a]        <= w[7:0];
        mem[a + 1'b1] <= w[15:8];
        mem[a + 2'd2] <= w[23:16];
        mem[a + 2'd3] <= w[31:24];
    endtask

    initial begin
        preload(20'h00000, 32'h00000000);
        preload(20'h00100, 32'hDEADBEEF);
        preload(20'h00200, 32'h00000000);
        preload(20'h00300, 32'hCAFEF00D);
        preload(20'hFFFFC, 32'h11223344);
        forever begin
            @(posedge clk);
            if (mem_we) begin
                mem[ma0]   <= mem_wdata[7:0];
                mem[ma1]   <= mem_wdata[15:8];
                mem[ma2]   <= mem_wdata[23:16];
                mem[ma3]   <= mem_wdata[31:24];
                mem_we_cnt <= mem_we_cnt + 1;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Driver: each requester presents the head of its queue until it sees req_ready.
    initial begin
        logic [NR-1:0] granted;
        for (int i = 0; i < NR; i++) rq_head[i] = 0;
        forever begin
            for (int i = 0; i < NR; i++) begin
                if (rq_head[i] < rq_cnt[i]) begin
                    req_valid[i]             = 1'b1;
                    req_we[i]                = rq[i][rq_head[i]].we;
                    req_addr[i*AW +: AW]     = rq[i][rq_head[i]].addr;
                    req_wdata[i*DW +: DW]    = rq[i][rq_head[i]].wdata;
                end else begin
                    req_valid[i]             = 1'b0;
                    req_we[i]                = 1'b0;
                    req_addr[i*AW +: AW]     = '0;
                    req_wdata[i*DW +: DW]    = '0;
                end
            end
            @(negedge clk);
            granted = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (granted[i]) begin
                    rq_head[i]++;
                    grant_log.push_back('{id: 32'(i), cyc: 32'(cyc)});
                end
            end
        end
    end

    // Monitor: every response pulse pops and checks the next scoreboard entry.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (req_ready != '0) begin
            check("ready_onehot_valid",
                  64'(($onehot(req_ready) && ((req_ready & ~req_valid) == '0)) ? 1 : 0), 64'd1);
        end
        if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_valid_id", 64'(rsp_valid), 64'(4'b0001 << e.id));
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    task automatic enq(input int id, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                       input logic exp_err, input bit expect_rsp);
        rq[id][rq_cnt[id]] = {we, addr, wdata};
        rq_cnt[id]++;
        if (expect_rsp) exp_q.push_back('{id: 2'(id), rdata: exp_rdata, err: exp_err});
    endtask

    function automatic bit pending_any();
        for (int i = 0; i < NR; i++) if (rq_head[i] < rq_cnt[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || pending_any() || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n >= 300), 64'd0);
        @(negedge clk);
    endtask

    task automatic wait_ready(input int id, input string name);
        int n = 0;
        while (!req_ready[id] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(req_ready[id]), 64'd1);
    endtask

    initial begin
        int base;
        for (int i = 0; i < NR; i++) rq_cnt[i] = 0;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // All four requesters valid from reset: grants 0,1,2,3,0, one every 3 cycles.
        base = grant_log.size();
        enq(0, 1'b0, 32'h100,   '0, 32'hDEADBEEF, 1'b0, 1'b1);
        enq(1, 1'b0, 32'h300,   '0, 32'hCAFEF00D, 1'b0, 1'b1);
        enq(2, 1'b0, 32'hFFFFC, '0, 32'h11223344, 1'b0, 1'b1);
        enq(3, 1'b0, 32'h0,     '0, 32'h00000000, 1'b0, 1'b1);
        enq(0, 1'b0, 32'h300,   '0, 32'hCAFEF00D, 1'b0, 1'b1);
        wait_done("rr_all_drain");
        check("rr_grant_count", 64'(grant_log.size() - base), 64'd5);
        if (grant_log.size() - base == 5) begin
            check("rr_g0", 64'(grant_log[base].id), 64'd0);
            check("rr_g1", 64'(grant_log[base+1].id), 64'd1);
            check("rr_g2", 64'(grant_log[base+2].id), 64'd2);
            check("rr_g3", 64'(grant_log[base+3].id), 64'd3);
            check("rr_g4", 64'(grant_log[base+4].id), 64'd0);
            for (int k = 1; k < 5; k++)
                check("rr_spacing", 64'(grant_log[base+k].cyc - grant_log[base+k-1].cyc), 64'd3);
        end

        // Single load from req0 with cycle-exact timing.
        enq(0, 1'b0, 32'h100, '0, 32'hDEADBEEF, 1'b0, 1'b1);
        wait_ready(0, "t1_ready0");
        @(negedge clk);
        check("t1_mem_addr", 64'(mem_addr), 64'h100);
        check("t1_mem_we", 64'(mem_we), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("t1_rsp_valid", 64'(rsp_valid), 64'b0001);
        check("t1_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        wait_done("t1_drain");

        // Store then load on req2; little-endian byte layout.
        enq(2, 1'b1, 32'h200, 32'h12345678, 32'h0, 1'b0, 1'b1);
        enq(2, 1'b0, 32'h200, '0, 32'h12345678, 1'b0, 1'b1);
        wait_done("t2_drain");
        check("t2_byte0", 64'(mem[20'h200]), 64'h78);
        check("t2_byte1", 64'(mem[20'h201]), 64'h56);
        check("t2_byte2", 64'(mem[20'h202]), 64'h34);
        check("t2_byte3", 64'(mem[20'h203]), 64'h12);

        // Error accesses never reach memory; the last legal word still reads.
        base = mem_we_cnt;
        enq(1, 1'b1, 32'h102,    32'hAAAA5555, 32'h0, 1'b1, 1'b1);
        enq(1, 1'b0, 32'hFFFFE,  '0,           32'h0, 1'b1, 1'b1);
        enq(1, 1'b0, 32'h100000, '0,           32'h0, 1'b1, 1'b1);
        enq(1, 1'b1, 32'hFFFFD,  32'h5A5A5A5A, 32'h0, 1'b1, 1'b1);
        enq(1, 1'b0, 32'hFFFFC,  '0, 32'h11223344, 1'b0, 1'b1);
        wait_done("t4_drain");
        check("t4_no_mem_we", 64'(mem_we_cnt), 64'(base));
        check("t4_word100", 64'(rd_word(20'h100)), 64'hDEADBEEF);
        check("t4_wordFFFFC", 64'(rd_word(20'hFFFFC)), 64'h11223344);

        // rr_ptr=2 (after a req1 grant) with req0 and req3 valid: req3 then req0.
        enq(1, 1'b0, 32'h100, '0, 32'hDEADBEEF, 1'b0, 1'b1);
        wait_done("t6_setup_drain");
        base = grant_log.size();
        enq(3, 1'b0, 32'h300,   '0, 32'hCAFEF00D, 1'b0, 1'b1);
        enq(0, 1'b0, 32'hFFFFC, '0, 32'h11223344, 1'b0, 1'b1);
        wait_done("t6_drain");
        check("t6_grant_count", 64'(grant_log.size() - base), 64'd2);
        if (grant_log.size() - base == 2) begin
            check("t6_first", 64'(grant_log[base].id), 64'd3);
            check("t6_second", 64'(grant_log[base+1].id), 64'd0);
        end

        // Reset during ACCESS of a store aborts it; arbitration restarts at req0.
        enq(2, 1'b1, 32'h300, 32'h55555555, 32'h0, 1'b0, 1'b0);
        wait_ready(2, "t5_ready2");
        @(posedge clk);
        #1;
        check("t5_pre_mem_we", 64'(mem_we), 64'd1);
        check("t5_pre_mem_addr", 64'(mem_addr), 64'h300);
        rst_n = 1'b0;
        #1;
        check("t5_mem_we", 64'(mem_we), 64'd0);
        check("t5_mem_addr", 64'(mem_addr), 64'd0);
        check("t5_mem_wdata", 64'(mem_wdata), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("t5_word300", 64'(rd_word(20'h300)), 64'hCAFEF00D);
        base = grant_log.size();
        enq(0, 1'b0, 32'h100, '0, 32'hDEADBEEF, 1'b0, 1'b1);
        enq(3, 1'b0, 32'h300, '0, 32'hCAFEF00D, 1'b0, 1'b1);
        wait_done("t5_drain");
        check("t5_grant_count", 64'(grant_log.size() - base), 64'd2);
        if (grant_log.size() - base == 2) begin
            check("t5_first", 64'(grant_log[base].id), 64'd0);
            check("t5_second", 64'(grant_log[base+1].id), 64'd3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
